// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC register and next-PC selector; BRANCH_DELAY_SLOT_EN enables the delay slot
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        redirect_pulse,
  output logic        misalign_err
);

  logic        advance;
  logic        live_req;
  logic [31:0] live_target;
  logic        live_mis;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        pend_mis;
  logic        sel_valid;
  logic [31:0] sel_target;
  logic        sel_mis;

  assign pc_plus4 = pc_out + PC_INC;
  assign advance  = imem_ready & ~stall;
  assign live_req = jr | jump | branch_taken;

  // Priority jr > jump > branch; jr targets are force-aligned but flagged.
  always_comb begin
    live_target = pc_plus4;
    live_mis    = 1'b0;
    if (jr) begin
      live_target = {jr_addr[31:2], 2'b00};
      live_mis    = |jr_addr[1:0];
    end else if (jump) begin
      live_target = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      live_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    end
  end

  // A live redirect on the advance cycle beats anything queued during a stall.
  always_comb begin
    sel_valid  = live_req | pend_valid;
    sel_target = live_req ? live_target : pend_target;
    sel_mis    = live_req ? live_mis : pend_mis;
  end

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {IDLE, SLOT} state_t;

  state_t      state;
  logic [31:0] slot_target;
  logic        slot_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out         <= RESET_PC;
      pend_valid     <= 1'b0;
      pend_target    <= 32'h0;
      pend_mis       <= 1'b0;
      state          <= IDLE;
      slot_target    <= 32'h0;
      slot_mis       <= 1'b0;
      redirect_pulse <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      redirect_pulse <= 1'b0;
      misalign_err   <= 1'b0;
      if (advance) begin
        pend_valid <= 1'b0;
        if (state == SLOT) begin
          pc_out         <= slot_target;
          redirect_pulse <= 1'b1;
          misalign_err   <= slot_mis;
          state          <= IDLE;
        end else begin
          pc_out <= pc_plus4;
          if (sel_valid) begin
            slot_target <= sel_target;
            slot_mis    <= sel_mis;
            state       <= SLOT;
          end
        end
      end else if (live_req && state == IDLE) begin
        pend_valid  <= 1'b1;
        pend_target <= live_target;
        pend_mis    <= live_mis;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out         <= RESET_PC;
      pend_valid     <= 1'b0;
      pend_target    <= 32'h0;
      pend_mis       <= 1'b0;
      redirect_pulse <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      redirect_pulse <= 1'b0;
      misalign_err   <= 1'b0;
      if (advance) begin
        pend_valid <= 1'b0;
        if (sel_valid) begin
          pc_out         <= sel_target;
          redirect_pulse <= 1'b1;
          misalign_err   <= sel_mis;
        end else begin
          pc_out <= pc_plus4;
        end
      end else if (live_req) begin
        pend_valid  <= 1'b1;
        pend_target <= live_target;
        pend_mis    <= live_mis;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect_pulse;
  logic        misalign_err;

  int tests_run = 0;
  int tests_failed = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .redirect_pulse(redirect_pulse), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued redirects kept as {misaligned, target} entries.
  logic [32:0] pend_q[$];
  logic [32:0] slot_q[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_pulse = 1'b0;
  logic        m_mis = 1'b0;

  always @(posedge clk) begin : scoreboard
    logic [31:0] p4, tgt, sext;
    logic        req, mis, adv;
    p4   = m_pc + 32'd4;
    sext = {{16{branch_offset[15]}}, branch_offset};
    req  = jr | jump | branch_taken;
    mis  = jr && (jr_addr[1:0] != 2'b00);
    if (jr)        tgt = jr_addr & ~32'd3;
    else if (jump) tgt = {p4[31:28], jump_target, 2'b00};
    else           tgt = p4 + sext * 32'd4;
    adv     = imem_ready && !stall;
    m_pulse = 1'b0;
    m_mis   = 1'b0;
    if (reset) begin
      m_pc = 32'h0;
      pend_q.delete();
      slot_q.delete();
    end else if (adv) begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (slot_q.size() != 0) begin
        {m_mis, m_pc} = slot_q.pop_front();
        m_pulse = 1'b1;
      end else begin
        if (req) slot_q.push_back({mis, tgt});
        else if (pend_q.size() != 0) slot_q.push_back(pend_q[0]);
        m_pc = p4;
      end
`else
      if (req) begin
        m_pc = tgt; m_mis = mis; m_pulse = 1'b1;
      end else if (pend_q.size() != 0) begin
        {m_mis, m_pc} = pend_q[0];
        m_pulse = 1'b1;
      end else begin
        m_pc = p4;
      end
`endif
      pend_q.delete();
`ifdef BRANCH_DELAY_SLOT_EN
    end else if (req && slot_q.size() == 0) begin
`else
    end else if (req) begin
`endif
      pend_q.delete();
      pend_q.push_back({mis, tgt});
    end
    #2;
    tests_run++;
    if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
        redirect_pulse !== m_pulse || misalign_err !== m_mis) begin
      tests_failed++;
      $display("FAIL model t=%0t: pc_out=%h plus4=%h pulse=%b mis=%b, expected pc_out=%h plus4=%h pulse=%b mis=%b",
               $time, pc_out, pc_plus4, redirect_pulse, misalign_err,
               m_pc, m_pc + 32'd4, m_pulse, m_mis);
    end
  end

  task automatic idle_inputs();
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = 16'h0;
    jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] a);
    idle_inputs();
    jr = 1'b1; jr_addr = a;
    tick();
    idle_inputs();
`ifdef BRANCH_DELAY_SLOT_EN
    tick();
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if (pc_out !== 32'h0 || redirect_pulse !== 1'b0 || misalign_err !== 1'b0 || pc_plus4 !== 32'h4) begin
      tests_failed++;
      $display("FAIL reset_state: pc_out=%h pulse=%b mis=%b plus4=%h, expected 0,0,0,4",
               pc_out, redirect_pulse, misalign_err, pc_plus4);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests_run++;
      if (pc_out !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL seq_fetch: pc_out=%h expected %h", pc_out, 32'(4 * i));
      end
    end
  endtask

`ifndef BRANCH_DELAY_SLOT_EN
  task automatic test_branch();
    load_pc(32'h100);
    branch_taken = 1'b1; branch_offset = 16'hFFFE;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h0FC || redirect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_neg: pc_out=%h pulse=%b expected 000000fc,1", pc_out, redirect_pulse);
    end
  endtask

  task automatic test_priority();
    load_pc(32'h0040_0010);
    jr = 1'b1; jump = 1'b1; jump_target = 26'h10; jr_addr = 32'h2000;
    branch_taken = 1'b1; branch_offset = 16'h0020;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h2000) begin
      tests_failed++;
      $display("FAIL jr_priority: pc_out=%h expected 00002000", pc_out);
    end
    jump = 1'b1; jump_target = 26'h10; branch_taken = 1'b1; branch_offset = 16'h0020;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h40) begin
      tests_failed++;
      $display("FAIL jump_priority: pc_out=%h expected 00000040", pc_out);
    end
  endtask

  task automatic test_stall_jump();
    load_pc(32'h40);
    stall = 1'b1; jump = 1'b1; jump_target = 26'h40;
    tick();
    jump = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (pc_out !== 32'h40 || redirect_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_hold: pc_out=%h pulse=%b expected 00000040,0", pc_out, redirect_pulse);
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if (pc_out !== 32'h100 || redirect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: pc_out=%h pulse=%b expected 00000100,1", pc_out, redirect_pulse);
    end
    tick();
    tests_run++;
    if (pc_out !== 32'h104) begin
      tests_failed++;
      $display("FAIL pending_cleared: pc_out=%h expected 00000104", pc_out);
    end
  endtask

  task automatic test_last_wins();
    load_pc(32'h200);
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0010;
    tick();
    branch_taken = 1'b0; imem_ready = 1'b0; stall = 1'b0;
    jr = 1'b1; jr_addr = 32'h3000;
    tick();
    jr = 1'b0; imem_ready = 1'b1;
    tick();
    tests_run++;
    if (pc_out !== 32'h3000) begin
      tests_failed++;
      $display("FAIL last_wins: pc_out=%h expected 00003000", pc_out);
    end
    load_pc(32'h200);
    stall = 1'b1; jr = 1'b1; jr_addr = 32'h3000;
    tick();
    jr = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_offset = 16'h0001;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h208) begin
      tests_failed++;
      $display("FAIL live_over_pending: pc_out=%h expected 00000208", pc_out);
    end
  endtask

  task automatic test_wrap_misalign();
    load_pc(32'hFFFF_FFFC);
    tick();
    tests_run++;
    if (pc_out !== 32'h0 || redirect_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap: pc_out=%h pulse=%b expected 00000000,0", pc_out, redirect_pulse);
    end
    jr = 1'b1; jr_addr = 32'h1003;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h1000 || misalign_err !== 1'b1 || redirect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign: pc_out=%h mis=%b pulse=%b expected 00001000,1,1",
               pc_out, misalign_err, redirect_pulse);
    end
    tick();
    tests_run++;
    if (misalign_err !== 1'b0 || pc_out !== 32'h1004) begin
      tests_failed++;
      $display("FAIL misalign_pulse: mis=%b pc_out=%h expected 0,00001004", misalign_err, pc_out);
    end
  endtask
`else
  task automatic test_delay_slot();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    branch_taken = 1'b1; branch_offset = 16'h0004;
    tick();
    idle_inputs();
    tests_run++;
    if (pc_out !== 32'h24 || redirect_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL ds_slot: pc_out=%h pulse=%b expected 00000024,0", pc_out, redirect_pulse);
    end
    tick();
    tests_run++;
    if (pc_out !== 32'h34 || redirect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL ds_target: pc_out=%h pulse=%b expected 00000034,1", pc_out, redirect_pulse);
    end
    branch_taken = 1'b1; branch_offset = 16'h0100;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (pc_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL ds_reset: pc_out=%h expected 00000000", pc_out);
    end
    tick(); tick();
    tests_run++;
    if (pc_out !== 32'h8 || redirect_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL ds_dropped: pc_out=%h pulse=%b expected 00000008,0", pc_out, redirect_pulse);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      imem_ready    = ($urandom_range(0, 9) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_offset = 16'($urandom);
      jump          = ($urandom_range(0, 9) == 0);
      jump_target   = 26'($urandom);
      jr            = ($urandom_range(0, 9) == 0);
      jr_addr       = $urandom;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
`ifndef BRANCH_DELAY_SLOT_EN
    test_branch();
    test_priority();
    test_stall_jump();
    test_last_wins();
    test_wrap_misalign();
`else
    test_delay_slot();
`endif
    test_random();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

endmodule
